instruct_issuer: RTL and testbench

Host-side issuer for the coprocessor's 32-bit instruction-word port. It accepts one request at a time (read slot, write data slot, or write key slot) over a valid/ready handshake. It serialises the request into the header-plus-payload word stream that the controller consumes on `instruct`. For reads, it captures the returned 32-bit `out` words into a 256-bit response. It sits between the system bus adapter and the controller.

---
 rtl/coproc_pkg.sv | 49 ++++
 rtl/rd_capture.sv | 36 +++
 rtl/instruct_issuer.sv | 210 +++++++++++++++++++++
 tb/tb_instruct_issuer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor host-side issuer: op encodings,
// the idle instruction word, payload/key length tables and the issuer FSM
// state encoding.
package coproc_pkg;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WDATA = 2'd1;
   localparam logic [1:0] OP_WKEY  = 2'd2;
   localparam logic [1:0] OP_NOP   = 2'd3;

   // Op field 3 with everything else zero: the controller ignores it.
   localparam logic [31:0] IDLE_WORD = 32'hC000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_GAP,
      ST_DATA,
      ST_WAIT,
      ST_RSP
   } state_t;

   // Number of payload words the controller expects for a write-data slot.
   function automatic logic [5:0] data_words(input logic [3:0] sel);
      logic [5:0] n;
      case (sel)
         4'd0, 4'd1, 4'd2, 4'd8, 4'd9: n = 6'd4;
         4'd5, 4'd6:                   n = 6'd8;
         4'd12, 4'd13, 4'd14:          n = 6'd5;
         4'd4:                         n = 6'd14;
         4'd7:                         n = 6'd2;
         default:                      n = 6'd1;
      endcase
      return n;
   endfunction

   // Number of cycles the controller spends loading a key slot.
   function automatic logic [5:0] key_words(input logic [3:0] sel);
      logic [5:0] n;
      case (sel)
         4'd0, 4'd1:       n = 6'd4;
         4'd2:             n = 6'd5;
         4'd3, 4'd4, 4'd5: n = 6'd32;
         default:          n = 6'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/rd_capture.sv
// Read-path capture buffer: eight 32-bit words, each written by index.
// words_next shows the buffer contents including a write landing this
// cycle, so the issuer can publish the full response on the same edge that
// captures the final word.
module rd_capture (
   input  logic         clock,
   input  logic         clear,
   input  logic         wr_en,
   input  logic [2:0]   wr_idx,
   input  logic [31:0]  wr_data,
   output logic [255:0] words_next
);

   logic [31:0] mem [8];

   // Merge the pending write over the stored words.
   always_comb begin
      words_next = '0;
      for (int i = 0; i < 8; i++) begin
         if (wr_en && (wr_idx == 3'(i)))
            words_next[32*i +: 32] = wr_data;
         else
            words_next[32*i +: 32] = mem[i];
      end
   end

   // Store the merged view; clear empties the buffer.
   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < 8; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++) mem[i] <= words_next[32*i +: 32];
      end
   end

endmodule

// File: rtl/instruct_issuer.sv
// Host-side issuer for the coprocessor instruction-word port. Accepts one
// read / write-data / write-key request, emits header + gap + payload on
// instruct, waits out the controller's latency, captures read words and
// pulses rsp_valid on completion.
//
// Optional feature macro: ISSUER_ERR_EN adds the rsp_err port; op 3 and
// write-key with sel > 5 then complete with rsp_err set.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; request fields are registered then, and the
// inputs are ignored until req_ready returns high (one cycle after the
// rsp_valid pulse). HDR_GAP must be at least 1.
module instruct_issuer
   import coproc_pkg::*;
#(
   parameter int HDR_GAP  = 2,
   parameter int RD_LAT   = 1,
   parameter int RD_WORDS = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [3:0]   req_sel,
   input  logic [255:0] req_data,
   output logic [31:0]  instruct,
   input  logic [31:0]  out_word,
   output logic         rsp_valid,
   output logic [255:0] rsp_data,
`ifdef ISSUER_ERR_EN
   output logic         rsp_err,
`endif
   output logic         busy
);

   localparam logic [5:0] GAP_LAST  = 6'(HDR_GAP - 1);
   localparam logic [5:0] RD_LAT6   = 6'(RD_LAT);
   localparam logic [5:0] RD_WORDS6 = 6'(RD_WORDS);
   localparam logic [5:0] RD_WAIT   = 6'(RD_LAT + RD_WORDS);

   state_t         state;
   logic [1:0]     op_r;
   logic [255:0]   data_r;
   logic [5:0]     pay_cnt;
   logic [5:0]     pay_len;
   logic [5:0]     wait_cnt;
   logic [5:0]     wait_last;
`ifdef ISSUER_ERR_EN
   logic           key_err_r;
`endif

   logic           cap_en;
   logic [5:0]     cap_off;
   logic [2:0]     cap_idx;
   logic [255:0]   cap_words;

   // Payload word k: request data for the first eight words, zero beyond.
   function automatic logic [31:0] payload_word(input logic [255:0] data,
                                                input logic [5:0] k);
      logic [31:0] w;
      if (k < 6'd8) w = data[32*k[2:0] +: 32];
      else          w = '0;
      return w;
   endfunction

   // Read capture window: WAIT cycles RD_LAT .. RD_LAT+RD_WORDS-1.
   always_comb begin
      cap_off = wait_cnt - RD_LAT6;
      cap_en  = (state == ST_WAIT) && (op_r == OP_READ) &&
                (wait_cnt >= RD_LAT6) && (cap_off < RD_WORDS6);
      cap_idx = cap_off[2:0];
   end

   rd_capture u_rd_capture (
      .clock      (clock),
      .clear      (reset),
      .wr_en      (cap_en),
      .wr_idx     (cap_idx),
      .wr_data    (out_word),
      .words_next (cap_words)
   );

   // Issuer FSM with all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         instruct  <= IDLE_WORD;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         op_r      <= OP_READ;
         data_r    <= '0;
         pay_cnt   <= '0;
         pay_len   <= '0;
         wait_cnt  <= '0;
         wait_last <= '0;
`ifdef ISSUER_ERR_EN
         rsp_err   <= 1'b0;
         key_err_r <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  op_r      <= req_op;
                  data_r    <= req_data;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  pay_cnt   <= '0;
                  wait_cnt  <= '0;
                  pay_len   <= data_words(req_sel);
                  case (req_op)
                     OP_READ:  wait_last <= RD_WAIT - 6'd1;
                     OP_WDATA: wait_last <= 6'd1;
                     default:  wait_last <= key_words(req_sel);
                  endcase
`ifdef ISSUER_ERR_EN
                  key_err_r <= (req_op == OP_WKEY) && (req_sel > 4'd5);
`endif
                  if (req_op == OP_NOP) begin
                     // Nothing goes to the controller; complete at once.
                     state     <= ST_RSP;
                     rsp_valid <= 1'b1;
`ifdef ISSUER_ERR_EN
                     rsp_err   <= 1'b1;
`endif
                  end else begin
                     state    <= ST_HDR;
                     instruct <= {req_op, 26'b0, req_sel};
                  end
               end
            end

            ST_HDR: begin
               instruct <= IDLE_WORD;
               wait_cnt <= '0;
`ifdef ISSUER_ERR_EN
               if (key_err_r) begin
                  // Invalid key slot: header has gone out, report error.
                  state     <= ST_RSP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else begin
                  state <= ST_GAP;
               end
`else
               state <= ST_GAP;
`endif
            end

            ST_GAP: begin
               if (wait_cnt == GAP_LAST) begin
                  wait_cnt <= '0;
                  if (op_r == OP_WDATA) begin
                     state    <= ST_DATA;
                     instruct <= payload_word(data_r, 6'd0);
                     pay_cnt  <= 6'd1;
                  end else begin
                     state <= ST_WAIT;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 6'd1;
               end
            end

            ST_DATA: begin
               if (pay_cnt == pay_len) begin
                  state    <= ST_WAIT;
                  instruct <= IDLE_WORD;
                  wait_cnt <= '0;
               end else begin
                  instruct <= payload_word(data_r, pay_cnt);
                  pay_cnt  <= pay_cnt + 6'd1;
               end
            end

            ST_WAIT: begin
               if (wait_cnt == wait_last) begin
                  state     <= ST_RSP;
                  rsp_valid <= 1'b1;
                  if (op_r == OP_READ) rsp_data <= cap_words;
               end else begin
                  wait_cnt <= wait_cnt + 6'd1;
               end
            end

            ST_RSP: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
`ifdef ISSUER_ERR_EN
               rsp_err   <= 1'b0;
`endif
            end

            default: begin
               state     <= ST_IDLE;
               instruct  <= IDLE_WORD;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruct_issuer.sv
// Self-checking bench for instruct_issuer. A reference model builds, per
// request, the cycle-by-cycle instruct stream and completion cycle from the
// slot length tables; outputs are compared on the falling edge.
// Build with ISSUER_ERR_EN defined to also cover rsp_err.
module tb_instruct_issuer;

   localparam int HDR_GAP  = 2;
   localparam int RD_LAT   = 1;
   localparam int RD_WORDS = 8;
   localparam logic [31:0] IDLE_W = 32'hC000_0000;

   logic         clock = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [3:0]   req_sel;
   logic [255:0] req_data;
   logic [31:0]  instruct;
   logic [31:0]  out_word;
   logic         rsp_valid;
   logic [255:0] rsp_data;
   logic         busy;
`ifdef ISSUER_ERR_EN
   logic         rsp_err;
`endif

   int checks   = 0;
   int failures = 0;

   // Slot length tables, indexed by sel.
   int dw_tab [16] = '{4, 4, 4, 1, 14, 8, 8, 2, 4, 4, 1, 1, 5, 5, 5, 1};
   int kw_tab [16] = '{4, 4, 5, 32, 32, 32, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

   logic [255:0] exp_rsp;

   instruct_issuer #(
      .HDR_GAP  (HDR_GAP),
      .RD_LAT   (RD_LAT),
      .RD_WORDS (RD_WORDS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_sel   (req_sel),
      .req_data  (req_data),
      .instruct  (instruct),
      .out_word  (out_word),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
`ifdef ISSUER_ERR_EN
      .rsp_err   (rsp_err),
`endif
      .busy      (busy)
   );

   // Clock
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_data();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   // Issue one request from an idle falling edge and check every cycle
   // until the first idle cycle afterwards.
   task automatic run_req(input logic [1:0] op, input logic [3:0] sel,
                          input logic [255:0] data, input bit rd_pattern);
      logic [31:0]  seq [$];
      logic [31:0]  rd_vals [8];
      logic [255:0] new_rsp;
      bit           err;
      int           n_pay, wlen, cap_start, n;

      // Reference model of the stream.
      err = 1'b0;
      seq = {};
      if (op == 2'd3) begin
`ifdef ISSUER_ERR_EN
         err = 1'b1;
`endif
      end else begin
         seq.push_back({op, 26'b0, sel});
`ifdef ISSUER_ERR_EN
         if (op == 2'd2 && sel > 4'd5) err = 1'b1;
`endif
         if (!err) begin
            for (int i = 0; i < HDR_GAP; i++) seq.push_back(IDLE_W);
            n_pay = (op == 2'd1) ? dw_tab[sel] : 0;
            for (int k = 0; k < n_pay; k++)
               seq.push_back((k < 8) ? data[32*k +: 32] : 32'h0);
            if (op == 2'd0)      wlen = RD_LAT + RD_WORDS;
            else if (op == 2'd1) wlen = 2;
            else                 wlen = kw_tab[sel] + 1;
            for (int i = 0; i < wlen; i++) seq.push_back(IDLE_W);
         end
      end
      seq.push_back(IDLE_W);  // completion cycle
      n = seq.size();

      // Cycle index (1 = header cycle) of returned word 0 for reads.
      cap_start = 2 + HDR_GAP + RD_LAT;
      new_rsp = exp_rsp;
      for (int k = 0; k < 8; k++) begin
         rd_vals[k] = rd_pattern ? (32'hA000_0000 + 32'(k)) : $urandom;
         if (op == 2'd0 && k < RD_WORDS) new_rsp[32*k +: 32] = rd_vals[k];
      end

      chk("ready_before_req", req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_sel   = sel;
      req_data  = data;
      @(posedge clock);
      for (int j = 1; j <= n; j++) begin
         @(negedge clock);
         // Junk on request inputs must be ignored while busy.
         req_valid = 1'b1;
         req_op    = 2'($urandom_range(0, 3));
         req_sel   = 4'($urandom_range(0, 15));
         req_data  = rand_data();
         if (op == 2'd0 && j >= cap_start && j < cap_start + RD_WORDS)
            out_word = rd_vals[j - cap_start];
         else
            out_word = $urandom;
         chk($sformatf("instruct_c%0d", j), instruct, seq[j-1]);
         chk($sformatf("rsp_valid_c%0d", j), rsp_valid, (j == n));
         chk($sformatf("ready_c%0d", j), req_ready, 0);
         chk($sformatf("busy_c%0d", j), busy, 1);
         chk($sformatf("rsp_data_c%0d", j), rsp_data,
             (j == n) ? new_rsp : exp_rsp);
`ifdef ISSUER_ERR_EN
         chk($sformatf("rsp_err_c%0d", j), rsp_err, (j == n) && err);
`endif
      end
      exp_rsp = new_rsp;
      @(negedge clock);
      req_valid = 1'b0;
      chk("ready_after", req_ready, 1);
      chk("busy_after", busy, 0);
      chk("instruct_after", instruct, IDLE_W);
      chk("rsp_valid_after", rsp_valid, 0);
   endtask

   initial begin
      logic [255:0] d;

      // Reset for three cycles.
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_sel   = 4'd0;
      req_data  = '0;
      out_word  = '0;
      exp_rsp   = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("reset_instruct", instruct, IDLE_W);
      chk("reset_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rsp_data", rsp_data, '0);
`ifdef ISSUER_ERR_EN
      chk("reset_rsp_err", rsp_err, 0);
`endif

      // Write data, sel 7: two payload words.
      d = rand_data();
      d[31:0]  = 32'h1111_1111;
      d[63:32] = 32'h2222_2222;
      run_req(2'd1, 4'd7, d, 1'b0);

      // Write data, sel 4: fourteen words, last six zero.
      run_req(2'd1, 4'd4, rand_data(), 1'b0);

      // Read, sel 3, returned words A0000000+k.
      run_req(2'd0, 4'd3, rand_data(), 1'b1);

      // Write key, sel 3: 33 wait cycles.
      run_req(2'd2, 4'd3, rand_data(), 1'b0);

      // Forbidden op.
      run_req(2'd3, 4'd9, rand_data(), 1'b0);

      // Write key with out-of-range sel.
      run_req(2'd2, 4'd11, rand_data(), 1'b0);

      // Randomized requests.
      for (int r = 0; r < 30; r++)
         run_req(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 rand_data(), 1'b0);

      // Reset during a payload word abandons the request.
      req_valid = 1'b1;
      req_op    = 2'd1;
      req_sel   = 4'd4;
      req_data  = rand_data();
      @(posedge clock);
      repeat (5) @(negedge clock);
      req_valid = 1'b0;
      chk("pre_reset_payload", instruct, req_data[63:32]);
      reset = 1'b1;
      @(negedge clock);
      reset   = 1'b0;
      exp_rsp = '0;
      chk("midreset_instruct", instruct, IDLE_W);
      chk("midreset_rsp_valid", rsp_valid, 0);
      chk("midreset_ready", req_ready, 1);
      chk("midreset_busy", busy, 0);
      chk("midreset_rsp_data", rsp_data, exp_rsp);
      for (int j = 0; j < 20; j++) begin
         @(negedge clock);
         chk("post_reset_rsp_valid", rsp_valid, 0);
         chk("post_reset_instruct", instruct, IDLE_W);
      end

      // Recovery after abandoned request.
      run_req(2'd0, 4'd1, rand_data(), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
